// File: rtl/cpu_multicycle_ctrl.sv
// Multicycle control FSM: FETCH -> DECODE -> EXEC -> {MEM} -> WB, with sticky ERR state.
// Optional performance counters (retired_cnt, stall_cnt) under `define PERF_COUNT_EN.
module cpu_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             flag_n,
  input  logic             flag_z,
  input  logic             flag_v,
  input  logic             flag_c,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             BrTaken,
  output logic             UncondBr,
  output logic             read_en,
  output logic             movz,
  output logic             movk,
  output logic             setFlag,
  output logic             addi,
  output logic             isLDURB,
  output logic [2:0]       ALUOp,
  output logic [3:0]       xfer_size,
  output logic             pc_en,
  output logic             err
`ifdef PERF_COUNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned TMO_W   = 8;
  localparam int unsigned XFER_W  = 4;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_e;

  typedef enum logic [3:0] {
    OP_ILL, OP_ADDI, OP_ADDS, OP_SUBS, OP_LDUR, OP_LDURB, OP_STUR, OP_STURB,
    OP_MOVZ, OP_MOVK, OP_B, OP_CBZ, OP_BLT
  } op_e;

  state_e             state, state_nx;
  logic [INSTR_W-1:0] instr_q;
  logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nx;
  op_e                op;
  logic [10:0]        opc;
  logic [4:0]         cond;
  logic               is_load, is_store, is_branch, is_byte, in_dp;
  logic               unused_bits;

  assign opc         = instr_q[31:21];
  assign cond        = instr_q[4:0];
  assign unused_bits = ^{flag_z, flag_c, instr_q[20:5]};

  // Opcode classification of the latched instruction
  always_comb begin
    op = OP_ILL;
    if (opc[10:5] == 6'b000101)                          op = OP_B;
    else if (opc[10:3] == 8'b10110100)                   op = OP_CBZ;
    else if (opc[10:3] == 8'b01010100 && cond == 5'h0B)  op = OP_BLT;
    else if (opc[10:1] == 10'b1001000100)                op = OP_ADDI;
    else if (opc[10:2] == 9'b110100101)                  op = OP_MOVZ;
    else if (opc[10:2] == 9'b111100101)                  op = OP_MOVK;
    else begin
      case (opc)
        11'b10101011000: op = OP_ADDS;
        11'b11101011000: op = OP_SUBS;
        11'b11111000010: op = OP_LDUR;
        11'b00111000010: op = OP_LDURB;
        11'b11111000000: op = OP_STUR;
        11'b00111000000: op = OP_STURB;
        default:         op = OP_ILL;
      endcase
    end
  end

  assign is_load   = (op == OP_LDUR)  || (op == OP_LDURB);
  assign is_store  = (op == OP_STUR)  || (op == OP_STURB);
  assign is_branch = (op == OP_B)     || (op == OP_CBZ) || (op == OP_BLT);
  assign is_byte   = (op == OP_LDURB) || (op == OP_STURB);
  assign in_dp     = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  // State, instruction register, memory timeout counter, sticky error
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      instr_q <= '0;
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= tmo_cnt_nx;
      if (instr_ready && instr_valid) instr_q <= instr;
      if (state_nx == S_ERR) err <= 1'b1;
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_nx    = state;
    tmo_cnt_nx  = tmo_cnt;
    instr_ready = 1'b0;
    Reg2Loc     = 1'b0;
    ALUSrc      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    BrTaken     = 1'b0;
    UncondBr    = 1'b0;
    read_en     = 1'b0;
    movz        = 1'b0;
    movk        = 1'b0;
    setFlag     = 1'b0;
    addi        = 1'b0;
    isLDURB     = 1'b0;
    ALUOp       = ALU_PASS;
    xfer_size   = XFER_W'(8);
    pc_en       = 1'b0;

    if (is_byte && state != S_FETCH && state != S_ERR) xfer_size = XFER_W'(1);

    // ALU operand/function selects stay put until the result is consumed
    if (in_dp) begin
      case (op)
        OP_ADDI:  begin ALUSrc = 1'b1; addi = 1'b1; ALUOp = ALU_ADD; end
        OP_ADDS:  begin Reg2Loc = 1'b1; ALUOp = ALU_ADD; end
        OP_SUBS:  begin Reg2Loc = 1'b1; ALUOp = ALU_SUB; end
        OP_MOVZ:  begin ALUSrc = 1'b1; movz = 1'b1; end
        OP_MOVK:  begin ALUSrc = 1'b1; movk = 1'b1; end
        OP_LDUR, OP_LDURB, OP_STUR, OP_STURB: begin ALUSrc = 1'b1; ALUOp = ALU_ADD; end
        default:  ;
      endcase
    end

    case (state)
      S_FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = (op == OP_ILL) ? S_ERR : S_EXEC;
      S_EXEC: begin
        setFlag = (op == OP_ADDS) || (op == OP_SUBS);
        if (is_branch) begin
          BrTaken  = (op == OP_B) || ((op == OP_CBZ) && alu_zero) ||
                     ((op == OP_BLT) && (flag_n != flag_v));
          UncondBr = (op == OP_B);
          pc_en    = 1'b1;
          state_nx = S_FETCH;
        end else if (is_load || is_store) begin
          tmo_cnt_nx = '0;
          state_nx   = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        read_en  = is_load;
        MemToReg = is_load;
        isLDURB  = (op == OP_LDURB);
        MemWrite = is_store;
        if (mem_ready) begin
          pc_en    = is_store;
          state_nx = is_store ? S_FETCH : S_WB;
        end else if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) begin
          state_nx = S_ERR;
        end else begin
          tmo_cnt_nx = tmo_cnt + TMO_W'(1);
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemToReg = is_load;
        isLDURB  = (op == OP_LDURB);
        pc_en    = 1'b1;
        state_nx = S_FETCH;
      end
      S_ERR:   state_nx = S_ERR;
      default: state_nx = S_ERR;
    endcase
  end

`ifdef PERF_COUNT_EN
  // Retirement and memory-stall counters, wrapping
  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_cnt <= '0;
      stall_cnt   <= '0;
    end else begin
      if (pc_en) retired_cnt <= retired_cnt + CNT_W'(1);
      if (state == S_MEM && !mem_ready) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Scoreboard bench for cpu_multicycle_ctrl: stimulus queues per-cycle control vectors,
// a negedge monitor pops and compares them (idle/err vectors when the queue is empty).
module tb_cpu_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid, instr_ready;
  logic        flag_n, flag_z, flag_v, flag_c, alu_zero, mem_ready;
  logic        Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, BrTaken, UncondBr;
  logic        read_en, movz, movk, setFlag, addi, isLDURB;
  logic [2:0]  ALUOp;
  logic [3:0]  xfer_size;
  logic        pc_en, err;
`ifdef PERF_COUNT_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  cpu_multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .flag_c(flag_c), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .BrTaken(BrTaken), .UncondBr(UncondBr), .read_en(read_en),
    .movz(movz), .movk(movk), .setFlag(setFlag), .addi(addi), .isLDURB(isLDURB),
    .ALUOp(ALUOp), .xfer_size(xfer_size), .pc_en(pc_en), .err(err)
`ifdef PERF_COUNT_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Control vector bit masks
  localparam logic [22:0] M_RDY    = 23'd1 << 22;
  localparam logic [22:0] M_R2L    = 23'd1 << 21;
  localparam logic [22:0] M_ALUSRC = 23'd1 << 20;
  localparam logic [22:0] M_M2R    = 23'd1 << 19;
  localparam logic [22:0] M_RW     = 23'd1 << 18;
  localparam logic [22:0] M_MW     = 23'd1 << 17;
  localparam logic [22:0] M_BR     = 23'd1 << 16;
  localparam logic [22:0] M_UBR    = 23'd1 << 15;
  localparam logic [22:0] M_RD     = 23'd1 << 14;
  localparam logic [22:0] M_MOVZ   = 23'd1 << 13;
  localparam logic [22:0] M_MOVK   = 23'd1 << 12;
  localparam logic [22:0] M_SETF   = 23'd1 << 11;
  localparam logic [22:0] M_ADDI   = 23'd1 << 10;
  localparam logic [22:0] M_LDB    = 23'd1 << 9;
  localparam logic [22:0] A_ADD    = 23'd2 << 6;
  localparam logic [22:0] A_SUB    = 23'd3 << 6;
  localparam logic [22:0] X8       = 23'd8 << 2;
  localparam logic [22:0] X1       = 23'd1 << 2;
  localparam logic [22:0] M_PC     = 23'd2;
  localparam logic [22:0] M_ERR    = 23'd1;
  localparam logic [22:0] V_IDLE   = M_RDY | X8;
  localparam logic [22:0] V_ERR    = M_ERR | X8;

  logic [22:0] act_v;
  assign act_v = {instr_ready, Reg2Loc, ALUSrc, MemToReg, RegWrite, MemWrite, BrTaken,
                  UncondBr, read_en, movz, movk, setFlag, addi, isLDURB, ALUOp,
                  xfer_size, pc_en, err};

  logic [22:0] exp_q[$];
  string       tag_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        mon_en, in_err;
  int          perf_seq = 0;
  int          exp_ret  = 0;
  int          exp_stall = 0;

  logic [22:0] mon_exp;
  string       mon_tag;
`ifdef PERF_COUNT_EN
  int          perf_seen = 0;
`endif

  // Monitor: every cycle is compared against the queued or background vector
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
      end else if (in_err) begin
        mon_exp = V_ERR;
        mon_tag = "err_hold";
      end else begin
        mon_exp = V_IDLE;
        mon_tag = "idle";
      end
      checks++;
      if (act_v !== mon_exp) begin
        failures++;
        $display("FAIL %s: got %06h want %06h", mon_tag, act_v, mon_exp);
      end
`ifdef PERF_COUNT_EN
      if (perf_seq != perf_seen) begin
        perf_seen = perf_seq;
        checks += 2;
        if (retired_cnt !== 32'(exp_ret)) begin
          failures++;
          $display("FAIL retired_cnt: got %0d want %0d", retired_cnt, exp_ret);
        end
        if (stall_cnt !== 32'(exp_stall)) begin
          failures++;
          $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, exp_stall);
        end
      end
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [22:0] v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  // Present a word during FETCH; returns one cycle after the accept edge (DECODE)
  task automatic issue(input logic [31:0] w);
    instr       = w;
    instr_valid = 1'b1;
    step(1);
    instr_valid = 1'b0;
    instr       = '0;
  endtask

  task automatic perf(input int r, input int s);
    exp_ret   = r;
    exp_stall = s;
    perf_seq++;
  endtask

  initial begin
    reset = 1'b0; instr = '0; instr_valid = 1'b0;
    flag_n = 1'b0; flag_z = 1'b0; flag_v = 1'b0; flag_c = 1'b0;
    alu_zero = 1'b0; mem_ready = 1'b0; mon_en = 1'b0; in_err = 1'b0;
    step(3);
    mon_en = 1'b1;
    reset  = 1'b1;
    perf(0, 0);
    step(1);

    // ADDI X1,X31,#5
    issue(32'h910017E1);
    push(X8, "addi_dec");
    push(M_ALUSRC | M_ADDI | A_ADD | X8, "addi_exec");
    push(M_ALUSRC | M_ADDI | A_ADD | M_RW | M_PC | X8, "addi_wb");
    step(3);

    // ADDS X4,X1,X2
    issue(32'hAB020024);
    push(X8, "adds_dec");
    push(M_R2L | A_ADD | M_SETF | X8, "adds_exec");
    push(M_R2L | A_ADD | M_RW | M_PC | X8, "adds_wb");
    step(3);

    // SUBS X3,X1,X2
    issue(32'hEB020023);
    push(X8, "subs_dec");
    push(M_R2L | A_SUB | M_SETF | X8, "subs_exec");
    push(M_R2L | A_SUB | M_RW | M_PC | X8, "subs_wb");
    step(3);

    // B.LT taken (N != V) and not taken (N == V)
    flag_n = 1'b1; flag_v = 1'b0;
    issue(32'h5400008B);
    push(X8, "blt_dec");
    push(M_BR | M_PC | X8, "blt_taken_exec");
    step(2);
    flag_v = 1'b1;
    issue(32'h5400008B);
    push(X8, "blt_dec2");
    push(M_PC | X8, "blt_nt_exec");
    step(2);

    // B
    issue(32'h14000010);
    push(X8, "b_dec");
    push(M_BR | M_UBR | M_PC | X8, "b_exec");
    step(2);

    // CBZ not taken, then taken
    alu_zero = 1'b0;
    issue(32'hB4000045);
    push(X8, "cbz_dec");
    push(M_PC | X8, "cbz_nt_exec");
    step(2);
    alu_zero = 1'b1;
    issue(32'hB4000045);
    push(X8, "cbz_dec2");
    push(M_BR | M_PC | X8, "cbz_taken_exec");
    step(2);
    alu_zero = 1'b0;

    // MOVZ, MOVK
    issue(32'hD2824687);
    push(X8, "movz_dec");
    push(M_ALUSRC | M_MOVZ | X8, "movz_exec");
    push(M_ALUSRC | M_MOVZ | M_RW | M_PC | X8, "movz_wb");
    step(3);
    issue(32'hF2824687);
    push(X8, "movk_dec");
    push(M_ALUSRC | M_MOVK | X8, "movk_exec");
    push(M_ALUSRC | M_MOVK | M_RW | M_PC | X8, "movk_wb");
    step(3);

    // LDURB with three wait cycles
    mem_ready = 1'b0;
    issue(32'h38400023);
    push(X1, "ldurb_dec");
    push(M_ALUSRC | A_ADD | X1, "ldurb_exec");
    for (int i = 0; i < 4; i++) push(M_ALUSRC | A_ADD | M_RD | M_M2R | M_LDB | X1, "ldurb_mem");
    push(M_ALUSRC | A_ADD | M_M2R | M_LDB | M_RW | M_PC | X1, "ldurb_wb");
    step(5);
    mem_ready = 1'b1;
    step(1);
    mem_ready = 1'b0;
    step(1);
    perf(11, 3);

    // LDUR with single-cycle memory
    mem_ready = 1'b1;
    issue(32'hF8400023);
    push(X8, "ldur_dec");
    push(M_ALUSRC | A_ADD | X8, "ldur_exec");
    push(M_ALUSRC | A_ADD | M_RD | M_M2R | X8, "ldur_mem");
    push(M_ALUSRC | A_ADD | M_M2R | M_RW | M_PC | X8, "ldur_wb");
    step(4);
    mem_ready = 1'b0;

    // STURB with one wait cycle, retires from MEM
    issue(32'h38000023);
    push(X1, "sturb_dec");
    push(M_ALUSRC | A_ADD | X1, "sturb_exec");
    push(M_ALUSRC | A_ADD | M_MW | X1, "sturb_mem_wait");
    push(M_ALUSRC | A_ADD | M_MW | M_PC | X1, "sturb_mem_done");
    step(3);
    mem_ready = 1'b1;
    step(1);
    mem_ready = 1'b0;
    perf(13, 4);

    // Reset in the middle of a load's MEM phase
    issue(32'hF8400023);
    push(X8, "rst_ld_dec");
    push(M_ALUSRC | A_ADD | X8, "rst_ld_exec");
    push(M_ALUSRC | A_ADD | M_RD | M_M2R | X8, "rst_ld_mem1");
    push(M_ALUSRC | A_ADD | M_RD | M_M2R | X8, "rst_ld_mem2");
    step(3);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    perf(0, 0);
    step(1);

    // STUR with memory never ready: timeout after 16 MEM cycles
    issue(32'hF8000023);
    push(X8, "stur_dec");
    push(M_ALUSRC | A_ADD | X8, "stur_exec");
    for (int i = 0; i < 16; i++) push(M_ALUSRC | A_ADD | M_MW | X8, "stur_mem");
    step(18);
    in_err      = 1'b1;
    instr_valid = 1'b1;
    instr       = 32'h910017E1;
    step(3);
    perf(0, 16);
    reset = 1'b0;
    step(1);
    reset = 1'b1; in_err = 1'b0; instr_valid = 1'b0; instr = '0;
    step(1);

    // Illegal opcode 0x00000000
    issue(32'h00000000);
    push(X8, "ill_dec");
    step(1);
    in_err = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
    reset = 1'b1; in_err = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
